// File: rtl/skewed_accum_bank_pkg.sv
// Shared accumulator types: write modes, sweep FSM states and the
// signed add helper used by every accumulator column.
//   acc_mode_e  : overwrite / accumulate selector
//   acc_state_e : clear-sweep controller states
//   sat_add     : width-generic signed add with overflow detect and
//                 optional clamping (operands carried in MAX_W bits)
package skewed_accum_bank_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic {
        ACC_OVERWRITE = 1'b0,
        ACC_ADD       = 1'b1
    } acc_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Only the low w bits of a, b and sum are meaningful; the sign bit is w-1.
    function automatic sat_res_t sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w,
        input logic             sat
    );
        sat_res_t         res;
        logic [5:0]       msb;
        logic [MAX_W-1:0] raw;
        logic [MAX_W-1:0] lim;
        msb     = 6'(w - 32'd1);
        raw     = a + b;
        lim     = 64'd1 << msb;
        res.ovf = (a[msb] == b[msb]) && (raw[msb] != a[msb]);
        if (sat && res.ovf) begin
            // Both operands share a sign: negative clamps to the most
            // negative value, positive to the most positive.
            if (a[msb]) begin
                res.sum = lim;
            end else begin
                res.sum = lim - 64'd1;
            end
        end else begin
            res.sum = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/skewed_accum_bank_accum_column.sv
// One column of the accumulator bank: DEPTH x DATA_W storage, a two-stage
// read-modify-write write path with S2->S1 forwarding, and a registered
// read port. Both ports address row (addr - COL_IDX) mod DEPTH.
//   clk_i, rst_i     : clock, synchronous active-low reset
//   wr_en_i          : write request (already masked and gated by the top)
//   acc_mode_i       : 0 overwrite, 1 accumulate
//   addr_wr_i, din_i : write base row, signed input word
//   rd_en_i, addr_rd_i, rd_data_o : registered read port
//   clr_en_i, clr_row_i : unskewed row zeroing from the clear sweep
//   ovf_o            : overflow/clamp flag of the word in S2
module accum_column
    import skewed_accum_bank_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IN_W     = 32,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned COL_IDX  = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              acc_mode_i,
    input  logic [AW-1:0]     addr_wr_i,
    input  logic [IN_W-1:0]   din_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     addr_rd_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_row_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_row_s;
    logic [AW-1:0]     rd_row_s;
    logic [DATA_W-1:0] din_ext_s;
    logic [DATA_W-1:0] old_s;
    logic [DATA_W-1:0] new_s;
    logic              new_ovf_s;
    sat_res_t          add_s;
    logic              unused_s;

    logic              s2_valid_r;
    logic [AW-1:0]     s2_row_r;
    logic [DATA_W-1:0] s2_data_r;
    logic              s2_ovf_r;
    logic [DATA_W-1:0] rd_data_r;

    // DEPTH is a power of two, so AW-bit subtraction is the modulo wrap.
    assign wr_row_s  = addr_wr_i - AW'(COL_IDX);
    assign rd_row_s  = addr_rd_i - AW'(COL_IDX);
    assign din_ext_s = DATA_W'($signed(din_i));
    // Upper bits of the wide helper result carry no information here.
    assign unused_s  = ^add_s.sum;

    // S1: fetch the old word (forwarded from S2 on a row hit) and compute the new one.
    always_comb begin
        if (s2_valid_r && (s2_row_r == wr_row_s)) begin
            old_s = s2_data_r;
        end else begin
            old_s = mem_r[wr_row_s];
        end
        add_s     = sat_add(MAX_W'(old_s), MAX_W'(din_ext_s), DATA_W, (SATURATE != 0));
        new_s     = din_ext_s;
        new_ovf_s = 1'b0;
        case (acc_mode_e'(acc_mode_i))
            ACC_ADD: begin
                new_s     = add_s.sum[DATA_W-1:0];
                new_ovf_s = add_s.ovf;
            end
            ACC_OVERWRITE: begin
                new_s     = din_ext_s;
                new_ovf_s = 1'b0;
            end
            default: begin
                new_s     = din_ext_s;
                new_ovf_s = 1'b0;
            end
        endcase
    end

    // S1 -> S2 pipeline register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s2_valid_r <= 1'b0;
            s2_row_r   <= {AW{1'b0}};
            s2_data_r  <= {DATA_W{1'b0}};
            s2_ovf_r   <= 1'b0;
        end else begin
            s2_valid_r <= wr_en_i;
            s2_row_r   <= wr_row_s;
            s2_data_r  <= new_s;
            s2_ovf_r   <= wr_en_i & new_ovf_s;
        end
    end

    // Storage write: clear sweep, otherwise S2 commit; nothing is written under reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (clr_en_i) begin
                mem_r[clr_row_i] <= {DATA_W{1'b0}};
            end else if (s2_valid_r) begin
                mem_r[s2_row_r] <= s2_data_r;
            end
        end
    end

    // Registered read port; the word is held until the next accepted read.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en_i) begin
            rd_data_r <= mem_r[rd_row_s];
        end
    end

    assign rd_data_o = rd_data_r;
    assign ovf_o     = s2_ovf_r;

endmodule

// File: rtl/skewed_accum_bank.sv
// Skewed accumulator bank: COLS accumulator columns addressed along the
// systolic array's output diagonal, plus the clear-sweep controller.
//   clk_i, rst_i : clock, synchronous active-low reset
//   wr_en_i, acc_mode_i, addr_wr_i, col_mask_i, data_i : write request
//   rd_en_i, addr_rd_i, data_o, valid_o : read port, one-cycle latency
//   clear_i, busy_o : start / status of the full-bank zeroing sweep
//   ovf_o        : sticky overflow/clamp flag
module skewed_accum_bank
    import skewed_accum_bank_pkg::*;
#(
    parameter int unsigned COLS     = 32,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IN_W     = 32,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic                   acc_mode_i,
    input  logic [AW-1:0]          addr_wr_i,
    input  logic [COLS-1:0]        col_mask_i,
    input  logic [COLS*IN_W-1:0]   data_i,
    input  logic                   rd_en_i,
    input  logic [AW-1:0]          addr_rd_i,
    output logic [COLS*DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   clear_i,
    output logic                   busy_o,
    output logic                   ovf_o
);

    acc_state_e    state_r;
    logic [AW-1:0] clr_row_r;
    logic          busy_r;
    logic          valid_r;
    logic          ovf_r;

    logic            accept_s;
    logic            clr_en_s;
    logic            any_ovf_s;
    logic [COLS-1:0] col_ovf_s;

    // Requests are taken only in IDLE, and not in the cycle that starts a sweep.
    assign accept_s  = (state_r == IDLE) && !clear_i;
    assign clr_en_s  = (state_r == CLEAR);
    assign any_ovf_s = |col_ovf_s;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        accum_column #(
            .DEPTH    (DEPTH),
            .DATA_W   (DATA_W),
            .IN_W     (IN_W),
            .SATURATE (SATURATE),
            .COL_IDX  (c)
        ) u_col (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_en_i   (wr_en_i && accept_s && col_mask_i[c]),
            .acc_mode_i(acc_mode_i),
            .addr_wr_i (addr_wr_i),
            .din_i     (data_i[c*IN_W +: IN_W]),
            .rd_en_i   (rd_en_i && accept_s),
            .addr_rd_i (addr_rd_i),
            .clr_en_i  (clr_en_s),
            .clr_row_i (clr_row_r),
            .rd_data_o (data_o[c*DATA_W +: DATA_W]),
            .ovf_o     (col_ovf_s[c])
        );
    end

    // Sweep FSM, read-valid and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r   <= IDLE;
            clr_row_r <= {AW{1'b0}};
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            valid_r <= rd_en_i && accept_s;
            case (state_r)
                IDLE: begin
                    if (clear_i) begin
                        state_r   <= DRAIN;
                        busy_r    <= 1'b1;
                        ovf_r     <= 1'b0;
                        clr_row_r <= {AW{1'b0}};
                    end else begin
                        ovf_r <= ovf_r | any_ovf_s;
                    end
                end
                DRAIN: begin
                    // One cycle for any S2 commit still in flight.
                    state_r <= CLEAR;
                    ovf_r   <= ovf_r | any_ovf_s;
                end
                CLEAR: begin
                    ovf_r <= ovf_r | any_ovf_s;
                    if (clr_row_r == AW'(DEPTH - 32'd1)) begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        clr_row_r <= {AW{1'b0}};
                    end else begin
                        clr_row_r <= clr_row_r + AW'(32'd1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = valid_r;
    assign busy_o  = busy_r;
    assign ovf_o   = ovf_r;

endmodule

// File: tb/tb_skewed_accum_bank.sv
// Directed bench: two 4x8, 8-bit banks (saturating and wrapping) share one
// stimulus stream; expected values are hand-computed constants.
module tb_skewed_accum_bank;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic        acc_mode_i;
    logic [2:0]  addr_wr_i;
    logic [3:0]  col_mask_i;
    logic [31:0] data_i;
    logic        rd_en_i;
    logic [2:0]  addr_rd_i;
    logic        clear_i;

    logic [31:0] data_sat, data_wrap;
    logic        valid_sat, valid_wrap, busy_sat, busy_wrap, ovf_sat, ovf_wrap;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    skewed_accum_bank #(.COLS(4), .DEPTH(8), .DATA_W(8), .IN_W(8), .SATURATE(1)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .acc_mode_i(acc_mode_i),
        .addr_wr_i(addr_wr_i), .col_mask_i(col_mask_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .addr_rd_i(addr_rd_i), .data_o(data_sat), .valid_o(valid_sat),
        .clear_i(clear_i), .busy_o(busy_sat), .ovf_o(ovf_sat)
    );

    skewed_accum_bank #(.COLS(4), .DEPTH(8), .DATA_W(8), .IN_W(8), .SATURATE(0)) dut_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .acc_mode_i(acc_mode_i),
        .addr_wr_i(addr_wr_i), .col_mask_i(col_mask_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .addr_rd_i(addr_rd_i), .data_o(data_wrap), .valid_o(valid_wrap),
        .clear_i(clear_i), .busy_o(busy_wrap), .ovf_o(ovf_wrap)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        clear_i = 1'b0;
        step();
    endtask

    task automatic wr(input logic [2:0] a, input logic m, input logic [3:0] mask, input logic [31:0] d);
        wr_en_i    = 1'b1;
        acc_mode_i = m;
        addr_wr_i  = a;
        col_mask_i = mask;
        data_i     = d;
        rd_en_i    = 1'b0;
        clear_i    = 1'b0;
        step();
        wr_en_i    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en_i   = 1'b1;
        addr_rd_i = a;
        wr_en_i   = 1'b0;
        clear_i   = 1'b0;
        step();
        rd_en_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [31:0] exp;
        int          row;

        rst_i = 1'b0; wr_en_i = 1'b0; acc_mode_i = 1'b0; addr_wr_i = 3'd0;
        addr_rd_i = 3'd0; col_mask_i = 4'h0; data_i = 32'h0; rd_en_i = 1'b0; clear_i = 1'b0;
        step();
        step();
        check("rst_valid", 32'(valid_sat), 32'd0);
        check("rst_data", data_sat, 32'h0);
        check("rst_busy", 32'(busy_sat), 32'd0);
        check("rst_ovf", 32'(ovf_sat), 32'd0);
        check("rst_valid_wrap", 32'(valid_wrap), 32'd0);
        check("rst_busy_wrap", 32'(busy_wrap), 32'd0);
        check("rst_ovf_wrap", 32'(ovf_wrap), 32'd0);
        rst_i = 1'b1;
        idle();

        // Overwrite + skewed read
        wr(3'd5, 1'b0, 4'hF, 32'h04030201);
        idle();
        rd(3'd5);
        check("skew_valid", 32'(valid_sat), 32'd1);
        check("skew_data", data_sat, 32'h04030201);
        check("skew_col3_row2", 32'(dut_sat.g_col[3].u_col.mem_r[2]), 32'h04);
        check("skew_col0_row5", 32'(dut_sat.g_col[0].u_col.mem_r[5]), 32'h01);
        idle();
        check("valid_drop", 32'(valid_sat), 32'd0);
        check("data_hold", data_sat, 32'h04030201);

        // Read in the commit cycle sees the pre-commit word
        wr(3'd5, 1'b0, 4'hF, 32'h09090909);
        rd(3'd5);
        check("no_rd_fwd", data_sat, 32'h04030201);
        rd(3'd5);
        check("post_commit", data_sat, 32'h09090909);

        // Back-to-back accumulate with forwarding: 10 + 3*5 = 25
        wr(3'd3, 1'b0, 4'hF, 32'h0A0A0A0A);
        wr(3'd3, 1'b1, 4'hF, 32'h05050505);
        wr(3'd3, 1'b1, 4'hF, 32'h05050505);
        wr(3'd3, 1'b1, 4'hF, 32'h05050505);
        idle();
        rd(3'd3);
        check("acc_fwd_sat", data_sat, 32'h19191919);
        check("acc_fwd_wrap", data_wrap, 32'h19191919);

        // Wrap-around rows and column mask
        wr(3'd0, 1'b0, 4'hF, 32'h44332211);
        idle();
        wr(3'd0, 1'b0, 4'b0101, 32'h88776655);
        idle();
        rd(3'd0);
        check("mask_data", data_sat, 32'h44772255);
        check("wrap_col2_row6", 32'(dut_sat.g_col[2].u_col.mem_r[6]), 32'h77);
        check("wrap_col0_row0", 32'(dut_sat.g_col[0].u_col.mem_r[0]), 32'h55);
        check("ovf_quiet_sat", 32'(ovf_sat), 32'd0);
        check("ovf_quiet_wrap", 32'(ovf_wrap), 32'd0);

        // Overflow: {120,120,-120,-120} + {20,20,-20,-20}
        wr(3'd1, 1'b0, 4'hF, 32'h88887878);
        wr(3'd1, 1'b1, 4'hF, 32'hECEC1414);
        idle();
        rd(3'd1);
        check("sat_clamp", data_sat, 32'h80807F7F);
        check("wrap_sum", data_wrap, 32'h74748C8C);
        check("sat_ovf", 32'(ovf_sat), 32'd1);
        check("wrap_ovf", 32'(ovf_wrap), 32'd1);

        // Clear sweep with pending write and read
        for (int a = 0; a < 7; a++) begin
            wr(3'(a), 1'b0, 4'hF, 32'h5A5A5A5A);
        end
        wr_en_i = 1'b1; addr_wr_i = 3'd7; acc_mode_i = 1'b0; col_mask_i = 4'hF;
        data_i = 32'h5A5A5A5A; rd_en_i = 1'b1; addr_rd_i = 3'd5;
        step();
        check("pre_clr_valid", 32'(valid_sat), 32'd1);
        check("pre_clr_data", data_sat, 32'h5A5A5A5A);
        clear_i = 1'b1; wr_en_i = 1'b1; addr_wr_i = 3'd4; data_i = 32'h33333333;
        rd_en_i = 1'b1; addr_rd_i = 3'd0;
        step();
        check("clr_busy", 32'(busy_sat), 32'd1);
        check("clr_rd_dropped", 32'(valid_sat), 32'd0);
        check("clr_data_hold", data_sat, 32'h5A5A5A5A);
        check("clr_ovf_sat", 32'(ovf_sat), 32'd0);
        check("clr_ovf_wrap", 32'(ovf_wrap), 32'd0);
        addr_wr_i = 3'd2; data_i = 32'h77777777;
        n = 0;
        while (busy_sat === 1'b1 && n < 64) begin
            n++;
            step();
            clear_i = 1'b0;
            wr_en_i = 1'b0;
            rd_en_i = 1'b0;
        end
        check("busy_cycles", 32'(n), 32'd9);
        check("busy_wrap_low", 32'(busy_wrap), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check($sformatf("cleared_addr%0d", a), data_sat, 32'h0);
        end
        check("post_clr_ovf", 32'(ovf_sat), 32'd0);

        // Reset during the sweep at row 3
        for (int a = 0; a < 8; a++) begin
            wr(3'(a), 1'b0, 4'hF, 32'h5A5A5A5A);
        end
        idle();
        rd(3'd6);
        check("pre_rst_data", data_sat, 32'h5A5A5A5A);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
        end
        rst_i = 1'b0;
        step();
        check("mid_rst_busy", 32'(busy_sat), 32'd0);
        check("mid_rst_valid", 32'(valid_sat), 32'd0);
        check("mid_rst_data", data_sat, 32'h0);
        check("mid_rst_ovf", 32'(ovf_sat), 32'd0);
        rst_i = 1'b1;
        idle();
        for (int a = 0; a < 8; a++) begin
            exp = 32'h0;
            for (int c = 0; c < 4; c++) begin
                row = (a - c) & 7;
                exp[c*8 +: 8] = (row < 3) ? 8'h00 : 8'h5A;
            end
            rd(3'(a));
            check($sformatf("partial_clr_addr%0d", a), data_sat, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/skewed_accum_bank.md
Name: skewed_accum_bank

Overview:
Parametrised successor to the systolic-array output accumulator. Holds DEPTH rows × COLS columns of partial sums, with diagonal (skewed) addressing matching the array's output wavefront. Adds a pipelined read-modify-write path with forwarding, a registered read port with valid, optional signed saturation with a sticky overflow flag, and a self-timed clear sweep. Sits between the MMU output and the activation unit.

Parameters:
COLS, 32, number of columns (array width)
DEPTH, 128, rows per column; power of two
DATA_W, 32, stored word width
IN_W, 32, input word width; IN_W <= DATA_W, sign-extended
SATURATE, 0, 1 = signed saturating add, 0 = wrap-around add
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
wr_en_i  in  1  write request
acc_mode_i  in  1  0 = overwrite, 1 = accumulate onto stored value
addr_wr_i  in  AW  write base row
col_mask_i  in  COLS  per-column write enable
data_i  in  COLS×IN_W  incoming column values, signed
rd_en_i  in  1  read request
addr_rd_i  in  AW  read base row
data_o  out  COLS×DATA_W  read data
valid_o  out  1  data_o valid
clear_i  in  1  start clear sweep
busy_o  out  1  clear sweep in progress
ovf_o  out  1  sticky saturation/overflow flag

Behaviour:
- Skew: column c accesses row (addr − c) mod DEPTH, for both read and write. Wrap is modulo DEPTH, with no error.
- Reset (rst_i=0 at a clock edge):
  - valid_o=0, data_o=0, busy_o=0, ovf_o=0.
  - Pipeline registers cleared; FSM to IDLE.
  - Storage contents are not reset.
  - Reset mid-sweep aborts the sweep.
- Write pipeline, 2 stages:
  - S1 (cycle t): capture request, mask and sign-extended data; read the old value of each targeted cell.
  - S2 (cycle t+1): commit to storage.
  - Overwrite commits the input. Accumulate commits old + input.
  - Masked-off columns are untouched.
- Forwarding: if S1 targets a cell that S2 commits in the same cycle, S1 uses S2's new value instead of storage. Back-to-back accumulates to the same address therefore sum correctly. Resolved per column.
- Arithmetic:
  - SATURATE=0: DATA_W-bit wrap. ovf_o sets on signed overflow.
  - SATURATE=1: clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; ovf_o sets when a clamp occurs.
  - ovf_o is sticky and clears only on reset or sweep start.
- Read port:
  - rd_en_i at cycle t gives data_o and valid_o=1 at t+1 (1-cycle latency).
  - valid_o=0 otherwise; data_o holds its last value.
  - Reads return committed storage. A read at t of a cell committed by S2 at t returns the pre-commit value (no read forwarding).
  - Reads and writes are independent and may both occur in the same cycle.
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE to DRAIN on clear_i: busy_o=1, ovf_o cleared; new wr_en_i/rd_en_i are dropped from this cycle.
  - DRAIN: lets an in-flight S2 commit (1 cycle), then moves to CLEAR.
  - CLEAR: zeroes one full row (all columns, unskewed) per cycle, rows 0..DEPTH−1.
  - After row DEPTH−1, return to IDLE; busy_o falls the following cycle.
  - Total busy time is DEPTH+1 cycles.
  - clear_i while busy_o=1 is ignored.
  - A read accepted the cycle before clear_i still returns valid data.
- Requests while busy_o=1 are dropped silently.

Decomposition:
- Extend the shared Acc_types package with:
  - acc_mode_e {ACC_OVERWRITE, ACC_ADD}
  - acc_state_e {IDLE, DRAIN, CLEAR}
  - sat_add function (parametrised by DATA_W, returns sum and overflow flag)
- One sub-module, accum_column: a single column's storage plus S1/S2 RMW, forwarding and saturation, instantiated COLS times with a column-index parameter for the skew offset.
- Top level holds the FSM, read valid, and the ovf_o OR-reduction.

Test Plan:
- Overwrite/read skew: COLS=4, DEPTH=8. Write addr 5, data {1,2,3,4}, full mask; read addr 5 → data_o={1,2,3,4} one cycle later, valid_o=1. Direct check: column 3 stored at row 2.
- Accumulate with forwarding: overwrite addr 3 = 10 in all columns, then accumulate +5 on three consecutive cycles at addr 3 → read returns 25 per column.
- Wrap and mask: write addr 0 with mask 4'b0101 → columns 0 and 2 written at rows 0 and 6; columns 1 and 3 unchanged.
- Saturation: SATURATE=1, DATA_W=8. Store 120, accumulate +20 → read 127, ovf_o=1. Same with SATURATE=0 → read −116, ovf_o=1.
- Clear sweep: fill all rows, pulse clear_i with a write pending → busy_o high exactly DEPTH+1 cycles; the write issued during busy is dropped; all reads after busy_o falls return 0; ovf_o=0.
- Reset mid-sweep: drop rst_i at sweep row 3 → next cycle busy_o=0, valid_o=0, FSM IDLE; rows ≥3 retain old data.
